// File: rtl/rf_arb_pkg.sv
// rtl/rf_arb_pkg.sv - shared types and constants for the register-file write-back arbiter
//
// Purpose : register-file geometry and the per-requester write record,
//           used by rf_wb_arbiter when it unpacks the flat request buses.
package rf_arb_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - parameterised round-robin grant with last-winner pointer
//
// Purpose : one-hot round-robin grant over N requesters. The search starts at
//           the port after the last winner. The pointer moves only when a grant
//           is actually issued while enabled.
// Ports   : i_clk, i_reset (async active-low)
//           i_req    [N-1:0]  request vector
//           i_enable          when low no grant is issued and the pointer holds
//           o_grant  [N-1:0]  one-hot grant, subset of i_req
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [N-1:0] i_req,
    input  logic         i_enable,
    output logic [N-1:0] o_grant
);

    localparam int             PW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0]  PTR_RST = PW'(N - 1);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] win;
    logic [N-1:0]  mask;
    logic [N-1:0]  req_hi;
    logic [N-1:0]  pick;

    // Requests strictly above the pointer take precedence; if there are none
    // the search wraps and the lowest-numbered request wins.
    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[i] = (i > int'(ptr_q));
        end
        req_hi = i_req & mask;
        pick   = (|req_hi) ? req_hi : i_req;

        o_grant = '0;
        win     = ptr_q;
        // Descending scan: the last hit is the lowest set bit.
        for (int i = N - 1; i >= 0; i--) begin
            if (pick[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
                win        = PW'(i);
            end
        end

        if (!i_enable) begin
            o_grant = '0;
        end
        ptr_d = (i_enable && (|pick)) ? win : ptr_q;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ptr_q <= PTR_RST;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter with long-latency scoreboard
//
// Purpose : shares the single register-file write port between the core
//           writeback (port 0, fixed top priority) and long-latency units
//           (ports 1..NUM_REQ-1, round-robin). It also keeps a per-register
//           busy scoreboard and reports source-operand hazards to decode.
// Ports   : i_clk, i_reset (async active-low)
//           i_req_valid/addr/data  packed per-requester write requests, port 0 in LSBs
//           o_req_ready            one-hot grant; a transfer is valid & ready
//           i_mark_valid/addr      long-latency op issued; mark its destination busy
//           i_rs1_addr/i_rs2_addr  decode source registers
//           o_rs1_busy/o_rs2_busy  source has a result pending (scoreboard or in-flight write)
//           o_rd_wren/addr/data    registered register-file write port
//           o_sb_busy              scoreboard vector, bit 0 always 0
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NUM_REQ = 3
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*REG_AW-1:0] i_req_addr,
    input  logic [NUM_REQ*XLEN-1:0]   i_req_data,
    output logic [NUM_REQ-1:0]        o_req_ready,
    input  logic                      i_mark_valid,
    input  logic [REG_AW-1:0]         i_mark_addr,
    input  logic [REG_AW-1:0]         i_rs1_addr,
    input  logic [REG_AW-1:0]         i_rs2_addr,
    output logic                      o_rs1_busy,
    output logic                      o_rs2_busy,
    output logic                      o_rd_wren,
    output logic [REG_AW-1:0]         o_rd_addr,
    output logic [XLEN-1:0]           o_rd_data,
    output logic [NUM_REGS-1:0]       o_sb_busy
);

    wb_req_t             req [NUM_REQ];
    wb_req_t             sel;
    logic [NUM_REQ-2:0]  rr_grant;
    logic                rr_enable;
    logic                xfer;

    logic                rd_wren_q, rd_wren_d;
    logic [REG_AW-1:0]   rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]     rd_data_q, rd_data_d;
    logic [NUM_REGS-1:0] sb_q,      sb_d;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req[i].addr = i_req_addr[i*REG_AW +: REG_AW];
            req[i].data = i_req_data[i*XLEN +: XLEN];
        end
    end

    // The round-robin only sees cycles where the core is not writing, so its
    // pointer is untouched while port 0 holds the write port.
    assign rr_enable = ~i_req_valid[0];

    rr_arbiter #(
        .N (NUM_REQ - 1)
    ) u_rr (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_req    (i_req_valid[NUM_REQ-1:1]),
        .i_enable (rr_enable),
        .o_grant  (rr_grant)
    );

    always_comb begin
        o_req_ready = i_req_valid[0] ? NUM_REQ'(1) : {rr_grant, 1'b0};
    end

    assign xfer = |(o_req_ready & i_req_valid);

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (o_req_ready[i]) begin
                sel = req[i];
            end
        end
    end

    // Write stage: a write to x0 is accepted and registered but never enabled.
    always_comb begin
        rd_wren_d = xfer && (sel.addr != '0);
        rd_addr_d = xfer ? sel.addr : rd_addr_q;
        rd_data_d = xfer ? sel.data : rd_data_q;
    end

    // Clear on the edge that commits the registered write, then apply the mark
    // so an issue to the same register in that cycle keeps the bit set.
    always_comb begin
        sb_d = sb_q;
        if (rd_wren_q) begin
            sb_d[rd_addr_q] = 1'b0;
        end
        if (i_mark_valid && (i_mark_addr != '0)) begin
            sb_d[i_mark_addr] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            rd_wren_q <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            sb_q      <= '0;
        end else begin
            rd_wren_q <= rd_wren_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            sb_q      <= sb_d;
        end
    end

    assign o_rd_wren = rd_wren_q;
    assign o_rd_addr = rd_addr_q;
    assign o_rd_data = rd_data_q;
    assign o_sb_busy = sb_q;

    // The in-flight term covers the cycle where the scoreboard bit is already
    // cleared-on-next-edge but the register file has not yet been written.
    assign o_rs1_busy = (i_rs1_addr != '0) &&
                        (sb_q[i_rs1_addr] || (rd_wren_q && (rd_addr_q == i_rs1_addr)));
    assign o_rs2_busy = (i_rs2_addr != '0) &&
                        (sb_q[i_rs2_addr] || (rd_wren_q && (rd_addr_q == i_rs2_addr)));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  valid;
    logic [4:0]  a [3];
    logic [31:0] d [3];
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  ready;
    logic        mark_valid;
    logic [4:0]  mark_addr;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] sb_busy;

    int checks;
    int passed;

    assign req_addr = {a[2], a[1], a[0]};
    assign req_data = {d[2], d[1], d[0]};

    rf_wb_arbiter #(
        .NUM_REQ (3)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_req_valid  (valid),
        .i_req_addr   (req_addr),
        .i_req_data   (req_data),
        .o_req_ready  (ready),
        .i_mark_valid (mark_valid),
        .i_mark_addr  (mark_addr),
        .i_rs1_addr   (rs1),
        .i_rs2_addr   (rs2),
        .o_rs1_busy   (rs1_busy),
        .o_rs2_busy   (rs2_busy),
        .o_rd_wren    (rd_wren),
        .o_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_sb_busy    (sb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        passed     = 0;
        rst_n      = 1'b0;
        valid      = 3'b111;
        a[0] = 5'd3;  d[0] = 32'h0000_0001;
        a[1] = 5'd4;  d[1] = 32'h0000_0002;
        a[2] = 5'd6;  d[2] = 32'h0000_0003;
        mark_valid = 1'b1;
        mark_addr  = 5'd3;
        rs1        = 5'd3;
        rs2        = 5'd4;

        // Reset with requests and marks active
        repeat (3) tick();
        check("rst_wren",  {31'b0, rd_wren},  32'd0);
        check("rst_addr",  {27'b0, rd_addr},  32'd0);
        check("rst_data",  rd_data,           32'd0);
        check("rst_sb",    sb_busy,           32'd0);
        check("rst_rs1",   {31'b0, rs1_busy}, 32'd0);
        check("rst_rs2",   {31'b0, rs2_busy}, 32'd0);

        // Round-robin between ports 1 and 2
        mark_valid = 1'b0;
        valid = 3'b110;
        a[1] = 5'd10; d[1] = 32'h1111_1111;
        a[2] = 5'd11; d[2] = 32'h2222_2222;
        rst_n = 1'b1;
        #1;
        check("rr_first",  {29'b0, ready}, 32'b010);
        tick();
        check("rr_wren1",  {31'b0, rd_wren}, 32'd1);
        check("rr_addr1",  {27'b0, rd_addr}, 32'd10);
        check("rr_data1",  rd_data,          32'h1111_1111);
        check("rr_g2",     {29'b0, ready},   32'b100);
        tick();
        check("rr_addr2",  {27'b0, rd_addr}, 32'd11);
        check("rr_data2",  rd_data,          32'h2222_2222);
        check("rr_g3",     {29'b0, ready},   32'b010);
        tick();
        check("rr_g4",     {29'b0, ready},   32'b100);

        // Port 0 priority; pointer must not move while port 0 wins
        valid = 3'b111;
        a[0] = 5'd5; d[0] = 32'hA5A5_A5A5;
        #1;
        check("pri_ready", {29'b0, ready}, 32'b001);
        tick();
        check("pri_wren",  {31'b0, rd_wren}, 32'd1);
        check("pri_addr",  {27'b0, rd_addr}, 32'd5);
        check("pri_data",  rd_data,          32'hA5A5_A5A5);
        valid = 3'b110;
        #1;
        check("rr_hold",   {29'b0, ready}, 32'b100);
        tick();
        check("rr_addr3",  {27'b0, rd_addr}, 32'd11);
        valid = 3'b000;
        tick();
        check("wren_pulse", {31'b0, rd_wren}, 32'd0);

        // Scoreboard mark / clear timing
        rs1 = 5'd7;
        rs2 = 5'd0;
        mark_valid = 1'b1;
        mark_addr  = 5'd7;
        #1;
        check("mark_lat",  {31'b0, rs1_busy}, 32'd0);
        tick();
        mark_valid = 1'b0;
        #1;
        check("mark_busy", {31'b0, rs1_busy}, 32'd1);
        check("mark_sb",   sb_busy,           32'h0000_0080);
        check("rs2_x0",    {31'b0, rs2_busy}, 32'd0);
        tick();
        tick();
        tick();
        valid = 3'b010;
        a[1] = 5'd7; d[1] = 32'h7777_7777;
        #1;
        check("sb_ready",  {29'b0, ready}, 32'b010);
        tick();
        valid = 3'b000;
        #1;
        check("inflight",  {31'b0, rs1_busy}, 32'd1);
        check("inf_wren",  {31'b0, rd_wren},  32'd1);
        check("inf_sb",    sb_busy,           32'h0000_0080);
        tick();
        check("cleared",   {31'b0, rs1_busy}, 32'd0);
        check("clr_sb",    sb_busy,           32'd0);

        // x0 handling
        mark_valid = 1'b1;
        mark_addr  = 5'd0;
        tick();
        mark_valid = 1'b0;
        check("x0_mark",   sb_busy, 32'd0);
        valid = 3'b100;
        a[2] = 5'd0; d[2] = 32'hFFFF_FFFF;
        #1;
        check("x0_ready",  {29'b0, ready}, 32'b100);
        tick();
        valid = 3'b000;
        check("x0_wren",   {31'b0, rd_wren}, 32'd0);
        check("x0_data",   rd_data,          32'hFFFF_FFFF);

        // Mark and clear of the same register in one cycle
        rs1 = 5'd9;
        mark_valid = 1'b1;
        mark_addr  = 5'd9;
        tick();
        mark_valid = 1'b0;
        check("m9_sb",     sb_busy, 32'h0000_0200);
        valid = 3'b001;
        a[0] = 5'd9; d[0] = 32'h9999_9999;
        tick();
        valid = 3'b000;
        mark_valid = 1'b1;
        mark_addr  = 5'd9;
        check("w9_wren",   {31'b0, rd_wren}, 32'd1);
        check("w9_addr",   {27'b0, rd_addr}, 32'd9);
        tick();
        mark_valid = 1'b0;
        #1;
        check("markwins",  sb_busy,           32'h0000_0200);
        check("mw_busy",   {31'b0, rs1_busy}, 32'd1);

        // Reset asserted while a write is in flight; pointer returns to reset value
        valid = 3'b010;
        a[1] = 5'd12; d[1] = 32'h0000_000C;
        mark_valid = 1'b1;
        mark_addr  = 5'd13;
        tick();
        valid = 3'b000;
        mark_valid = 1'b0;
        check("pre_wren",  {31'b0, rd_wren}, 32'd1);
        check("pre_sb",    sb_busy,          32'h0000_2200);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_wren",  {31'b0, rd_wren}, 32'd0);
        check("mid_sb",    sb_busy,          32'd0);
        check("mid_addr",  {27'b0, rd_addr}, 32'd0);
        tick();
        rst_n = 1'b1;
        valid = 3'b110;
        #1;
        check("rst_ptr",   {29'b0, ready}, 32'b010);
        valid = 3'b000;
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
